// File: rtl/lsu.sv
// Memory stage: runs the data-memory handshake for loads/stores, aligns and extends load data,
// and hands exactly one result per instruction to writeback. One instruction in flight at a time.
module lsu #(
    parameter int DATA_WIDTH     = 64,
    parameter int FUNC3_WIDTH    = 3,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_is_load,
    input  logic                      in_is_store,
    input  logic [FUNC3_WIDTH-1:0]    in_func3,
    input  logic [DATA_WIDTH-1:0]     in_alu_res,
    input  logic [DATA_WIDTH-1:0]     in_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    output logic                      dmem_req_valid,
    input  logic                      dmem_req_ready,
    output logic [DATA_WIDTH-1:0]     dmem_req_addr,
    output logic                      dmem_req_we,
    output logic [DATA_WIDTH-1:0]     dmem_req_wdata,
    output logic [7:0]                dmem_req_wmask,
    input  logic                      dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     dmem_resp_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_wen,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [1:0]                out_exc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

    state_t                    state_reg, state_next;
    logic [FUNC3_WIDTH-1:0]    func3_reg, func3_next;
    logic                      is_load_reg, is_load_next;
    logic [2:0]                offset_reg, offset_next;
    logic [DATA_WIDTH-1:0]     req_addr_reg, req_addr_next;
    logic                      req_we_reg, req_we_next;
    logic [DATA_WIDTH-1:0]     req_wdata_reg, req_wdata_next;
    logic [7:0]                req_wmask_reg, req_wmask_next;
    logic [REG_ADDR_WIDTH-1:0] out_rd_reg, out_rd_next;
    logic                      out_wen_reg, out_wen_next;
    logic [DATA_WIDTH-1:0]     out_data_reg, out_data_next;
    logic [1:0]                out_exc_reg, out_exc_next;

    // Decode of the instruction on offer; only consumed in IDLE.
    logic                  in_mem;
    logic                  in_store;
    logic [2:0]            in_off;
    logic [3:0]            in_size;
    logic                  in_misaligned;
    logic                  in_illegal;
    logic [7:0]            in_wmask;
    logic [DATA_WIDTH-1:0] in_wdata;

    assign in_mem     = in_is_load | in_is_store;
    assign in_store   = in_is_store & ~in_is_load;
    assign in_off     = in_alu_res[2:0];
    assign in_size    = 4'd1 << in_func3[1:0];
    assign in_illegal = in_store & in_func3[2];
    assign in_wdata   = in_store_data << {in_off, 3'b000};

    always_comb begin
        case (in_func3[1:0])
            2'b00:   in_misaligned = 1'b0;
            2'b01:   in_misaligned = in_off[0];
            2'b10:   in_misaligned = |in_off[1:0];
            default: in_misaligned = |in_off;
        endcase
    end

    // Byte lane gi is enabled when it lies inside [offset, offset + size).
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        localparam logic [3:0] LANE = 4'(gi);
        assign in_wmask[gi] = ({1'b0, in_off} <= LANE) && (LANE < ({1'b0, in_off} + in_size));
    end

    // Load alignment and extension from the captured offset/func3.
    logic [DATA_WIDTH-1:0] resp_shifted;
    logic                  load_sign;
    logic [DATA_WIDTH-1:0] load_value;

    assign resp_shifted = dmem_resp_data >> {offset_reg, 3'b000};
    assign load_sign    = ~func3_reg[2];

    always_comb begin
        case (func3_reg[1:0])
            2'b00:   load_value = {{(DATA_WIDTH-8){load_sign & resp_shifted[7]}}, resp_shifted[7:0]};
            2'b01:   load_value = {{(DATA_WIDTH-16){load_sign & resp_shifted[15]}}, resp_shifted[15:0]};
            2'b10:   load_value = {{(DATA_WIDTH-32){load_sign & resp_shifted[31]}}, resp_shifted[31:0]};
            default: load_value = resp_shifted;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        func3_next     = func3_reg;
        is_load_next   = is_load_reg;
        offset_next    = offset_reg;
        req_addr_next  = req_addr_reg;
        req_we_next    = req_we_reg;
        req_wdata_next = req_wdata_reg;
        req_wmask_next = req_wmask_reg;
        out_rd_next    = out_rd_reg;
        out_wen_next   = out_wen_reg;
        out_data_next  = out_data_reg;
        out_exc_next   = out_exc_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    func3_next     = in_func3;
                    is_load_next   = in_is_load;
                    offset_next    = in_off;
                    req_addr_next  = {in_alu_res[DATA_WIDTH-1:3], 3'b000};
                    req_we_next    = in_store;
                    req_wdata_next = in_wdata;
                    req_wmask_next = in_wmask;
                    out_rd_next    = in_rd;
                    out_wen_next   = 1'b0;
                    out_data_next  = '0;
                    out_exc_next   = 2'd0;
                    if (in_illegal) begin
                        out_exc_next = 2'd3;
                        state_next   = DONE;
                    end else if (in_mem && in_misaligned) begin
                        out_exc_next = in_is_load ? 2'd1 : 2'd2;
                        state_next   = DONE;
                    end else if (in_mem) begin
                        state_next = REQ;
                    end else begin
                        out_data_next = in_alu_res;
                        out_wen_next  = |in_rd;
                        state_next    = DONE;
                    end
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (dmem_resp_valid) begin
                    // A store response is only an acknowledgement.
                    out_data_next = is_load_reg ? load_value : '0;
                    out_wen_next  = is_load_reg & (|out_rd_reg);
                    state_next    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            func3_reg     <= '0;
            is_load_reg   <= 1'b0;
            offset_reg    <= '0;
            req_addr_reg  <= '0;
            req_we_reg    <= 1'b0;
            req_wdata_reg <= '0;
            req_wmask_reg <= '0;
            out_rd_reg    <= '0;
            out_wen_reg   <= 1'b0;
            out_data_reg  <= '0;
            out_exc_reg   <= 2'd0;
        end else begin
            state_reg     <= state_next;
            func3_reg     <= func3_next;
            is_load_reg   <= is_load_next;
            offset_reg    <= offset_next;
            req_addr_reg  <= req_addr_next;
            req_we_reg    <= req_we_next;
            req_wdata_reg <= req_wdata_next;
            req_wmask_reg <= req_wmask_next;
            out_rd_reg    <= out_rd_next;
            out_wen_reg   <= out_wen_next;
            out_data_reg  <= out_data_next;
            out_exc_reg   <= out_exc_next;
        end
    end

    assign in_ready       = (state_reg == IDLE) && !reset;
    assign dmem_req_valid = (state_reg == REQ);
    assign dmem_req_addr  = req_addr_reg;
    assign dmem_req_we    = req_we_reg;
    assign dmem_req_wdata = req_wdata_reg;
    assign dmem_req_wmask = req_wmask_reg;
    assign out_valid      = (state_reg == DONE);
    assign out_rd         = out_rd_reg;
    assign out_wen        = out_wen_reg;
    assign out_data       = out_data_reg;
    assign out_exc        = out_exc_reg;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized instructions against a
// byte-level reference model of load/store behaviour.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_func3;
    logic [63:0] in_alu_res;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_wmask;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [63:0] out_data;
    logic [1:0]  out_exc;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_func3       (in_func3),
        .in_alu_res     (in_alu_res),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_req_wmask (dmem_req_wmask),
        .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data (dmem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rd         (out_rd),
        .out_wen        (out_wen),
        .out_data       (out_data),
        .out_exc        (out_exc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] model_exc(input logic ld, input logic st,
                                             input logic [2:0] f3, input logic [63:0] addr);
        int sz = size_of(f3);
        if (st && !ld && f3[2]) return 2'd3;
        if ((ld || st) && (int'(addr[2:0]) % sz) != 0) return ld ? 2'd1 : 2'd2;
        return 2'd0;
    endfunction

    // Gather size bytes starting at the address offset, then extend.
    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr,
                                               input logic [63:0] word);
        int          off = int'(addr[2:0]);
        int          sz  = size_of(f3);
        logic [63:0] v   = 64'd0;
        logic [7:0]  b;
        for (int i = 0; i < sz; i++) begin
            b = word[8*(off+i) +: 8];
            v = v | (64'(b) << (8*i));
        end
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        return v;
    endfunction

    function automatic logic [7:0] model_wmask(input logic [2:0] f3, input logic [63:0] addr);
        logic [15:0] m = ((16'd1 << size_of(f3)) - 16'd1) << addr[2:0];
        return m[7:0];
    endfunction

    task automatic scramble_inputs();
        in_is_load    = 1'($urandom);
        in_is_store   = 1'($urandom);
        in_func3      = 3'($urandom);
        in_alu_res    = {$urandom, $urandom};
        in_store_data = {$urandom, $urandom};
        in_rd         = 5'($urandom);
    endtask

    // Called at a falling edge (or #1 after it) with the DUT idle.
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [63:0] alu, input logic [63:0] sdata, input logic [4:0] rd,
                           input logic [63:0] word, input int req_wait, input int resp_wait,
                           input int out_wait);
        logic [1:0]  e_exc;
        logic        mem;
        logic        store;
        logic        e_wen;
        logic [63:0] e_data;
        e_exc = model_exc(ld, st, f3, alu);
        mem   = (ld || st) && (e_exc == 2'd0);
        store = st && !ld;
        if (e_exc != 2'd0) begin
            e_wen = 1'b0; e_data = 64'd0;
        end else if (ld) begin
            e_wen = (rd != 5'd0); e_data = model_load(f3, alu, word);
        end else if (st) begin
            e_wen = 1'b0; e_data = 64'd0;
        end else begin
            e_wen = (rd != 5'd0); e_data = alu;
        end
        $display("txn ld=%0b st=%0b f3=%0d addr=0x%0h rd=%0d -> exc=%0d wen=%0b data=0x%0h",
                 ld, st, f3, alu, rd, e_exc, e_wen, e_data);

        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_func3 = f3;
        in_alu_res = alu; in_store_data = sdata; in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();

        if (mem) begin
            for (int c = 0; c <= req_wait; c++) begin
                dmem_req_ready  = (c == req_wait);
                dmem_resp_valid = (c < req_wait);
                dmem_resp_data  = {$urandom, $urandom};
                #1;
                check("req_valid", dmem_req_valid, 1'b1);
                check("req_addr", dmem_req_addr, {alu[63:3], 3'b000});
                check("req_we", dmem_req_we, store);
                if (store) begin
                    check("req_wdata", dmem_req_wdata, sdata << (8 * int'(alu[2:0])));
                    check("req_wmask", dmem_req_wmask, model_wmask(f3, alu));
                end
                check("in_ready_busy", in_ready, 1'b0);
                check("out_valid_early", out_valid, 1'b0);
                @(negedge clk);
            end
            dmem_req_ready  = 1'b0;
            dmem_resp_valid = 1'b0;
            for (int c = 0; c <= resp_wait; c++) begin
                dmem_resp_valid = (c == resp_wait);
                dmem_resp_data  = (c == resp_wait) ? word : {$urandom, $urandom};
                #1;
                check("req_valid_wait", dmem_req_valid, 1'b0);
                check("out_valid_wait", out_valid, 1'b0);
                @(negedge clk);
            end
            dmem_resp_valid = 1'b0;
            dmem_resp_data  = {$urandom, $urandom};
        end

        for (int c = 0; c <= out_wait; c++) begin
            out_ready = (c == out_wait);
            #1;
            check("out_valid", out_valid, 1'b1);
            check("out_rd", out_rd, rd);
            check("out_wen", out_wen, e_wen);
            check("out_exc", out_exc, e_exc);
            if (e_exc == 2'd0) check("out_data", out_data, e_data);
            check("no_req_in_done", dmem_req_valid, 1'b0);
            check("in_ready_done", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        #1;
        check("out_valid_after", out_valid, 1'b0);
        check("in_ready_after", in_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        dmem_resp_data = 64'd0; out_ready = 1'b0;
        scramble_inputs();
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_req_valid", dmem_req_valid, 1'b0);
        check("rst_req_we", dmem_req_we, 1'b0);
        check("rst_wmask", dmem_req_wmask, 8'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_wen", out_wen, 1'b0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_rd", out_rd, 5'd0);
        check("rst_out_exc", out_exc, 2'd0);
        reset = 1'b0;
        #1;

        // Directed cases.
        run_txn(0, 0, 3'b000, 64'h1234, 64'd0, 5'd5, 64'd0, 0, 0, 0);
        run_txn(1, 0, 3'b000, 64'h1003, 64'd0, 5'd7, 64'h00000000_80000000, 0, 0, 0);
        run_txn(1, 0, 3'b100, 64'h1003, 64'd0, 5'd7, 64'h00000000_80000000, 0, 1, 0);
        run_txn(0, 1, 3'b001, 64'h2006, 64'hABCD, 5'd3, 64'h0, 0, 0, 0);
        run_txn(1, 0, 3'b010, 64'h3002, 64'd0, 5'd4, 64'd0, 0, 0, 0);
        run_txn(0, 1, 3'b100, 64'h5000, 64'h55, 5'd4, 64'd0, 0, 0, 0);
        run_txn(1, 0, 3'b011, 64'h4000, 64'd0, 5'd9, 64'h0123_4567_89AB_CDEF, 3, 0, 2);
        run_txn(1, 1, 3'b010, 64'h6004, 64'h77, 5'd10, 64'h8765_4321_0000_0000, 1, 0, 0);
        run_txn(1, 0, 3'b001, 64'h7002, 64'd0, 5'd0, 64'h0000_0000_F00F_0000, 0, 2, 1);
        run_txn(0, 1, 3'b011, 64'h8001, 64'h1, 5'd2, 64'd0, 0, 0, 0);

        // Reset while waiting for a response, then a late response.
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_func3 = 3'b011;
        in_alu_res = 64'h4000; in_rd = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_out_wen", out_wen, 1'b0);
        check("midrst_out_rd", out_rd, 5'd0);
        check("midrst_req_valid", dmem_req_valid, 1'b0);
        dmem_resp_valid = 1'b1; dmem_resp_data = 64'hDEAD_BEEF_0000_1111;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("late_resp_out_valid", out_valid, 1'b0);
            check("late_resp_out_wen", out_wen, 1'b0);
            @(negedge clk);
        end
        #1;
        check("late_resp_in_ready", in_ready, 1'b1);

        // Randomized instructions.
        for (int n = 0; n < 250; n++) begin
            logic        ld, st;
            logic [2:0]  f3;
            logic [63:0] addr;
            int          kind;
            kind = $urandom_range(0, 3);
            ld   = (kind == 1) || (kind == 3);
            st   = (kind == 2) || (kind == 3);
            f3   = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) addr = addr & ~64'(size_of(f3) - 1);
            run_txn(ld, st, f3, addr, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
